// File: rtl/path_pkg.sv
// Shared constants, node type and state encoding for the path follower.
package path_pkg;

    localparam int unsigned NUM_NODES = 37;
    localparam int unsigned NODE_W    = 6;
    localparam int unsigned MAX_LEN   = 37;
    localparam int unsigned PATH_END  = 37;

    typedef logic [NODE_W-1:0] node_t;

    // Node-typed copies so comparisons against node_t values stay width-exact
    localparam node_t END_NODE  = node_t'(PATH_END);
    localparam node_t NODE_CNT  = node_t'(NUM_NODES);
    localparam node_t LAST_SLOT = node_t'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        FIN,
        ERR
    } state_t;

endpackage

// File: rtl/path_buffer.sv
// Path slot storage: all slots written at once, one indexed read port.
module path_buffer
    import path_pkg::*;
(
    input  logic                      clk,
    input  logic                      load,
    input  logic [MAX_LEN*NODE_W-1:0] path_flat,
    input  node_t                     rd_idx,
    output node_t                     rd_data
);

    node_t mem [MAX_LEN];

    // Capture the whole path in one cycle when a new path is accepted
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                mem[i] <= path_flat[i*NODE_W +: NODE_W];
            end
        end
    end

    // Reads past the last slot return the terminator
    always_comb begin
        rd_data = END_NODE;
        if (rd_idx <= LAST_SLOT) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/path_follower.sv
// Walks a terminated next-hop list, issuing one from/to command per hop and
// waiting for arrival before the next. Optional arrival watchdog is enabled
// by defining ARRIVE_TIMEOUT_EN.
module path_follower
    import path_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  node_t                     start_node,
    input  logic [MAX_LEN*NODE_W-1:0] path_flat,
    input  logic                      path_valid,
    output logic                      path_ready,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output node_t                     cmd_from,
    output node_t                     cmd_to,
    output logic                      cmd_last,
    input  logic                      node_reached,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output node_t                     hop_idx
);

`ifdef ARRIVE_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
`endif

    state_t state_q, state_d;
    node_t  scan_q, scan_d;
    node_t  len_q, len_d;
    node_t  hop_q, hop_d;
    node_t  cur_q, cur_d;
    logic   cmd_valid_q, cmd_valid_d;
    node_t  cmd_from_q, cmd_from_d;
    node_t  cmd_to_q, cmd_to_d;
    logic   cmd_last_q, cmd_last_d;
    logic   load;
    logic   to_err;
    node_t  rd_idx;
    node_t  rd_data;

    path_buffer u_buf (
        .clk       (clk),
        .load      (load),
        .path_flat (path_flat),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    // State and command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            scan_q      <= '0;
            len_q       <= '0;
            hop_q       <= '0;
            cur_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_from_q  <= '0;
            cmd_to_q    <= '0;
            cmd_last_q  <= 1'b0;
`ifdef ARRIVE_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            scan_q      <= scan_d;
            len_q       <= len_d;
            hop_q       <= hop_d;
            cur_q       <= cur_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_from_q  <= cmd_from_d;
            cmd_to_q    <= cmd_to_d;
            cmd_last_q  <= cmd_last_d;
`ifdef ARRIVE_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    // Next-state, path validation scan and hop sequencing
    always_comb begin
        state_d     = state_q;
        scan_d      = scan_q;
        len_d       = len_q;
        hop_d       = hop_q;
        cur_d       = cur_q;
        cmd_valid_d = cmd_valid_q;
        cmd_from_d  = cmd_from_q;
        cmd_to_d    = cmd_to_q;
        cmd_last_d  = cmd_last_q;
        load        = 1'b0;
        to_err      = 1'b0;
        rd_idx      = hop_q;
`ifdef ARRIVE_TIMEOUT_EN
        wd_d        = wd_q;
`endif
        unique case (state_q)
            IDLE, ERR: begin
                if (path_valid) begin
                    load    = 1'b1;
                    cur_d   = start_node;
                    hop_d   = '0;
                    scan_d  = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                rd_idx = scan_q;
                // Slot 0 is the first hop; grab it now since the read port
                // is busy with the scan until the terminator is found
                if (scan_q == '0) begin
                    cmd_to_d = rd_data;
                end
                if (rd_data == END_NODE) begin
                    len_d = scan_q;
                    if (scan_q == '0) begin
                        to_err = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        cmd_valid_d = 1'b1;
                        cmd_from_d  = cur_q;
                        cmd_last_d  = (scan_q == node_t'(1));
                    end
                end else if (rd_data >= NODE_CNT || scan_q == LAST_SLOT) begin
                    to_err = 1'b1;
                end else begin
                    scan_d = scan_q + node_t'(1);
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = WAIT;
`ifdef ARRIVE_TIMEOUT_EN
                    wd_d        = '0;
`endif
                end
            end
            WAIT: begin
                rd_idx = hop_q + node_t'(1);
                // Arrival wins over a watchdog expiry in the same cycle
                if (node_reached) begin
                    cur_d = cmd_to_q;
                    if (cmd_last_q) begin
                        state_d = FIN;
                    end else begin
                        hop_d       = hop_q + node_t'(1);
                        cmd_valid_d = 1'b1;
                        cmd_from_d  = cmd_to_q;
                        cmd_to_d    = rd_data;
                        cmd_last_d  = ((hop_q + node_t'(2)) == len_q);
                        state_d     = ISSUE;
                    end
                end
`ifdef ARRIVE_TIMEOUT_EN
                else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    to_err = 1'b1;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (to_err) begin
            state_d     = ERR;
            cmd_valid_d = 1'b0;
            cmd_from_d  = '0;
            cmd_to_d    = '0;
            cmd_last_d  = 1'b0;
        end
    end

    // Status outputs decoded from state; ERR loads paths like IDLE
    always_comb begin
        path_ready = (state_q == IDLE) || (state_q == ERR);
        busy       = !path_ready;
        done       = (state_q == FIN);
        error      = (state_q == ERR);
        cmd_valid  = cmd_valid_q;
        cmd_from   = cmd_from_q;
        cmd_to     = cmd_to_q;
        cmd_last   = cmd_last_q;
        hop_idx    = hop_q;
    end

endmodule
